sr_register_file_mp: RTL



---
 rtl/sr_rf_pkg.sv | 22 ++
 rtl/sr_rf_scoreboard.sv | 69 ++++++
 rtl/sr_register_file_mp.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sr_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_rf_pkg
//  Description : Shared types and helpers for the multi-port register file:
//                FSM state encoding and the address-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_rf_pkg;

    // Clear engine state: INIT sweeps zeros through the array, RUN is normal use
    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    // Address width for a register count; never narrower than one bit
    function automatic int rf_aw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : sr_rf_scoreboard
//  Description : Per-register pending-write bits. Decode sets a bit when it
//                issues a producer, writeback clears it. Set beats clear on
//                the same address (a newer producer was issued).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_en            - 1 in RUN; bits are held at 0 otherwise
//                i_set/_addr     - mark register pending
//                i_clr/_addr     - writeback completed for register
//                i_rd_addr       - per-port lookup addresses
//                i_byp           - per-port "this read is being forwarded"
//                o_rd_busy       - per-port pending flag
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_rf_scoreboard
    import sr_rf_pkg::*;
#(
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_set,
    input  logic [AW-1:0]           i_set_addr,
    input  logic                    i_clr,
    input  logic [AW-1:0]           i_clr_addr,
    input  logic [NRD-1:0][AW-1:0]  i_rd_addr,
    input  logic [NRD-1:0]          i_byp,
    output logic [NRD-1:0]          o_rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Clear first, then set, so a same-address set wins. Bit 0 is x0 and
    // can never be pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr) begin
            w_busy_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set) begin
            w_busy_nxt[i_set_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A forwarded read already has its value, so it is not reported busy
    always_comb begin
        o_rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            o_rd_busy[i] = i_en && (i_rd_addr[i] != '0) && !i_byp[i]
                           && r_busy[i_rd_addr[i]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sr_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : sr_register_file_mp
//  Description : Parametrised register file with NRD combinational read
//                ports, optional write-to-read bypass, pending-write
//                scoreboard, debug read port and a sequential clear engine
//                that zeroes every register after reset.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                o_ready             - clear sequence finished
//                i_rd_addr/o_rd_data - read ports (packed per port)
//                o_rd_busy           - per-port pending-write flag
//                i_wr_en/addr/data   - writeback port
//                i_sb_set/i_sb_addr  - scoreboard set from decode
//                i_dbg_addr/o_dbg_data - debug read, never bypassed
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_register_file_mp
    import sr_rf_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NRD    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = rf_aw(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     o_ready,
    input  logic [NRD-1:0][AW-1:0]   i_rd_addr,
    output logic [NRD-1:0][XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]           o_rd_busy,
    input  logic                     i_wr_en,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [XLEN-1:0]          i_wr_data,
    input  logic                     i_sb_set,
    input  logic [AW-1:0]            i_sb_addr,
    input  logic [AW-1:0]            i_dbg_addr,
    output logic [XLEN-1:0]          o_dbg_data
);

    rf_state_t       r_state;
    rf_state_t       w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic [XLEN-1:0] r_rf [NREGS];

    logic            w_run;
    logic            w_wr_run;
    logic            w_rf_we;
    logic [AW-1:0]   w_rf_waddr;
    logic [XLEN-1:0] w_rf_wdata;
    logic [NRD-1:0]  w_byp;

    assign w_run    = (r_state == RF_RUN);
    assign w_wr_run = i_wr_en && w_run;
    assign o_ready  = w_run;

    // ---------------- FSM / clear counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RF_INIT: begin
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == AW'(NREGS - 1)) begin
                    w_state_nxt = RF_RUN;
                end
            end
            RF_RUN:  w_state_nxt = RF_RUN;
            default: w_state_nxt = RF_INIT;
        endcase
    end

    // ---------------- storage ----------------
    // INIT owns the write port (zero sweep); writeback is ignored there.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = i_wr_addr;
        w_rf_wdata = i_wr_data;
        if (!w_run) begin
            w_rf_we    = 1'b1;
            w_rf_waddr = r_cnt;
            w_rf_wdata = '0;
        end else begin
            w_rf_we = i_wr_en && (i_wr_addr != '0);
        end
    end

    // No reset on the array: contents are defined by the clear sweep.
    // rst blocks writes so a writeback coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_rf_we) begin
            r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        w_byp     = '0;
        o_rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            w_byp[i] = (BYPASS != 0) && w_wr_run && (i_wr_addr == i_rd_addr[i]);
            if (!w_run || (i_rd_addr[i] == '0)) begin
                o_rd_data[i] = '0;
            end else if (w_byp[i]) begin
                o_rd_data[i] = i_wr_data;
            end else begin
                o_rd_data[i] = r_rf[i_rd_addr[i]];
            end
        end
    end

    assign o_dbg_data = (w_run && (i_dbg_addr != '0)) ? r_rf[i_dbg_addr] : '0;

    // ---------------- scoreboard ----------------
    sr_rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_run),
        .i_set      (i_sb_set),
        .i_set_addr (i_sb_addr),
        .i_clr      (w_wr_run),
        .i_clr_addr (i_wr_addr),
        .i_rd_addr  (i_rd_addr),
        .i_byp      (w_byp),
        .o_rd_busy  (o_rd_busy)
    );

endmodule
`default_nettype wire
